// File: rtl/e_calc_pkg.sv
// e_calc_pkg: shared states, word type and the fixed-point 1.0 constant for e_calc_power
package e_calc_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int ONE_MAX = 4096;
  typedef logic [WORD_W_DEF-1:0] word_t;
  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_SQ_GO,
    S_SQ_WAIT,
    S_MUL_GO,
    S_MUL_WAIT,
    S_FIN,
    S_DRAIN
  } state_t;
  // 1.0 sits at the lowest integer bit, i.e. just above the fraction words
  function automatic logic [ONE_MAX-1:0] one_val(input int frac_bits);
    one_val = ONE_MAX'(1) << frac_bits;
  endfunction
endpackage

// File: rtl/e_multi.sv
// e_multi: fixed-point multiplier, p = trunc(a*b / 2^F); done arrives WORDS*WORD_W+1 cycles after start
module e_multi #(
  parameter int WORDS  = 32,
  parameter int WORD_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [WORDS*WORD_W-1:0]   i_a,
  input  logic [WORDS*WORD_W-1:0]   i_b,
  output logic                      o_done,
  output logic [WORDS*WORD_W-1:0]   o_p
);
  localparam int N  = WORDS * WORD_W;
  localparam int F  = WORD_W * (WORDS - 1);
  localparam int PW = N + F;
  localparam int CW = $clog2(N + 1);
  logic [N-1:0]  r_a, r_b;
  logic [PW-1:0] r_p;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  // MSB-first shift-add; bits above PW only ever hold integer overflow, so they are never kept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_p   <= '0;
        r_cnt <= CW'(N);
      end else if (r_cnt != '0) begin
        r_p    <= {r_p[PW-2:0], 1'b0} + (r_b[N-1] ? PW'(r_a) : '0);
        r_b    <= {r_b[N-2:0], 1'b0};
        r_cnt  <= r_cnt - CW'(1);
        r_done <= r_cnt == CW'(1);
      end
    end
  end
  assign o_done = r_done;
  assign o_p    = r_p[PW-1:F];
endmodule

// File: rtl/e_calc_power.sv
// e_calc_power: base^exp by MSB-first square-and-multiply over one shared e_multi
module e_calc_power
  import e_calc_pkg::*;
#(
  parameter int WORDS  = 32,
  parameter int WORD_W = 16,
  parameter int EXP_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [0:WORDS-1][WORD_W-1:0]    base,
  input  logic [EXP_W-1:0]                exp,
  output logic                            busy,
  output logic                            done,
  output logic [0:WORDS-1][WORD_W-1:0]    result
);
  localparam int N  = WORDS * WORD_W;
  localparam int F  = WORD_W * (WORDS - 1);
  localparam int IW = $clog2(EXP_W);
  localparam logic [N-1:0] ONE = N'(one_val(F));
  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_base, r_acc, r_result, w_prod, w_mb;
  logic [EXP_W-1:0] r_exp;
  logic [IW-1:0]  r_idx;
  logic           r_mstart, w_mdone, w_bit, w_last, w_dec, w_accept;
  assign w_bit    = r_exp[r_idx];
  assign w_last   = r_idx == '0;
  assign w_accept = r_state == S_IDLE && start && !abort;
  assign w_mb     = r_state == S_MUL_GO ? r_base : r_acc;
  assign busy     = r_state != S_IDLE;
  assign done     = r_state == S_FIN && !abort;
  assign result   = done ? r_acc : r_result;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     w_state_nxt = w_accept ? S_LOAD : S_IDLE;
      S_LOAD:     w_state_nxt = abort ? S_IDLE : S_SCAN;
      S_SCAN:     w_state_nxt = abort ? S_IDLE : w_last ? S_FIN : w_bit ? S_SQ_GO : S_SCAN;
      S_SQ_GO:    w_state_nxt = abort ? S_IDLE : S_SQ_WAIT;
      S_MUL_GO:   w_state_nxt = abort ? S_IDLE : S_MUL_WAIT;
      S_SQ_WAIT:  w_state_nxt = abort ? (w_mdone ? S_IDLE : S_DRAIN) :
                                !w_mdone ? S_SQ_WAIT : w_bit ? S_MUL_GO : w_last ? S_FIN : S_SQ_GO;
      S_MUL_WAIT: w_state_nxt = abort ? (w_mdone ? S_IDLE : S_DRAIN) :
                                !w_mdone ? S_MUL_WAIT : w_last ? S_FIN : S_SQ_GO;
      S_FIN:      w_state_nxt = S_IDLE;
      S_DRAIN:    w_state_nxt = w_mdone ? S_IDLE : S_DRAIN;
      default:    w_state_nxt = S_IDLE;
    endcase
  end
  // the index steps down on every scanned bit and whenever a new square begins
  assign w_dec = w_state_nxt == S_SQ_GO || (r_state == S_SCAN && w_state_nxt == S_SCAN);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_exp    <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_mstart <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mstart <= w_state_nxt == S_SQ_GO || w_state_nxt == S_MUL_GO;
      if (w_accept) begin
        r_base <= base;
        r_exp  <= exp;
        r_idx  <= IW'(EXP_W - 1);
      end else if (w_dec) begin
        r_idx <= r_idx - IW'(1);
      end
      if (r_state == S_SCAN && (w_bit || w_last))
        r_acc <= w_bit ? r_base : ONE;
      else if ((r_state == S_SQ_WAIT || r_state == S_MUL_WAIT) && w_mdone && !abort)
        r_acc <= w_prod;
      if (done)
        r_result <= r_acc;
    end
  end
  e_multi #(.WORDS(WORDS), .WORD_W(WORD_W)) u_multi (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_mstart),
    .i_a     (r_acc),
    .i_b     (w_mb),
    .o_done  (w_mdone),
    .o_p     (w_prod)
  );
endmodule

// File: tb/tb_e_calc_power.sv
// tb_e_calc_power: random and directed checks of e_calc_power against a transaction-level model
module tb_e_calc_power;
  localparam int WORDS = 4, WORD_W = 16, EXP_W = 16;
  localparam int T = WORDS * WORD_W + 1;
  localparam logic [63:0] ONE = 64'h0001_0000_0000_0000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [63:0] base = '0;
  logic [15:0] exp_i = '0;
  logic busy, done;
  logic [63:0] result;
  int cyc = 0, checks = 0, errors = 0;
  bit chk_en = 1'b0;
  e_calc_power #(.WORDS(WORDS), .WORD_W(WORD_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base(base), .exp(exp_i),
    .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask
  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'b0, a} * {64'b0, b};
    return p[111:48];
  endfunction
  function automatic int hi_bit(input logic [15:0] e);
    hi_bit = -1;
    for (int i = 0; i < 16; i++) if (e[i]) hi_bit = i;
  endfunction
  function automatic logic [63:0] pow_model(input logic [63:0] b, input logic [15:0] e);
    logic [63:0] acc;
    if (e == 0) return ONE;
    acc = b;
    for (int i = hi_bit(e) - 1; i >= 0; i--) begin
      acc = fmul(acc, acc);
      if (e[i]) acc = fmul(acc, b);
    end
    return acc;
  endfunction
  function automatic int lat_of(input logic [15:0] e);
    int p;
    p = hi_bit(e);
    return e == 0 ? 3 + EXP_W - 1 : 3 + (EXP_W - 1 - p) + (p + $countones(e) - 1) * (T + 1);
  endfunction
  int m_phase = 0, m_s = 0, m_L = 0, m_off0 = 0, m_ops = 0, m_drain_end = 0;
  logic [63:0] m_val = '0, m_result = '0;
  always @(negedge clk) begin : cmp
    logic e_done;
    int d;
    e_done = m_phase == 1 && cyc - m_s == m_L && !abort;
    if (chk_en) begin
      chk("busy", busy, m_phase != 0);
      chk("done", done, e_done);
      chk("result", result, e_done ? m_val : m_result);
    end
    d = cyc - m_s;
    if (rst) begin
      m_phase = 0;
      m_result = '0;
    end else if (m_phase == 0) begin
      if (start && !abort) begin
        m_phase = 1;
        m_s = cyc;
        m_val = pow_model(base, exp_i);
        m_L = lat_of(exp_i);
        m_off0 = exp_i == 0 ? 0 : 3 + EXP_W - 1 - hi_bit(exp_i);
        m_ops = exp_i == 0 ? 0 : hi_bit(exp_i) + $countones(exp_i) - 1;
      end
    end else if (m_phase == 1) begin
      if (d == m_L) begin
        m_phase = 0;
        if (!abort) m_result = m_val;
      end else if (abort) begin
        m_phase = 0;
        if (m_ops > 0 && d >= m_off0 && (d - m_off0) % (T + 1) != 0 && (d - m_off0) % (T + 1) != T) begin
          m_phase = 2;
          m_drain_end = m_s + m_off0 + ((d - m_off0) / (T + 1)) * (T + 1) + T;
        end
      end
    end else if (cyc == m_drain_end) begin
      m_phase = 0;
    end
  end
  task automatic run_op(input logic [63:0] b, input logic [15:0] e, output logic [63:0] r, output int lat);
    int s;
    @(posedge clk); #1 start = 1'b1; base = b; exp_i = e; s = cyc;
    @(posedge clk); #1 start = 1'b0; base = {$urandom, $urandom}; exp_i = 16'($urandom);
    do @(negedge clk); while (!done && cyc - s < 5000);
    chk("op_done", done, 1'b1);
    r = result;
    lat = cyc - s;
  endtask
  initial begin
    logic [63:0] r, r_keep, b;
    logic [15:0] e;
    int lat, s, mode, k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
    run_op(64'h0002_0000_0000_0000, 16'd10, r, lat);
    chk("pow_2_10", r, 64'h0400_0000_0000_0000); chk("lat_2_10", lat, 279);
    @(negedge clk); chk("idle_after", busy, 0);
    run_op(64'h0001_8000_0000_0000, 16'd2, r, lat);
    chk("pow_1p5_2", r, 64'h0002_4000_0000_0000); chk("lat_1p5_2", lat, 83);
    run_op({$urandom, $urandom}, 16'd0, r, lat);
    chk("pow_exp0", r, ONE); chk("lat_exp0", lat, 18);
    run_op(64'h0001_0002_0000_0000, 16'h8000, r, lat);
    chk("e_model", r, pow_model(64'h0001_0002_0000_0000, 16'h8000));
    chk("e_int", r[63:48], 16'd2); chk("e_frac_hi", r[47:40], 8'hB7); chk("lat_e", lat, 993);
    r_keep = r;
    @(posedge clk); #1 start = 1'b1; base = 64'h0003_0000_0000_0000; exp_i = 16'd5; s = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < s + 26) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    do @(negedge clk); while (busy && cyc - s < 1000);
    chk("drain_end", cyc - s, 82); chk("abort_result", result, r_keep);
    run_op(64'h0003_0000_0000_0000, 16'd3, r, lat);
    chk("pow_3_3", r, 64'h001B_0000_0000_0000); chk("lat_3_3", lat, 149);
    @(posedge clk); #1 start = 1'b1; base = 64'h0003_0000_0000_0000; exp_i = 16'd3; s = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < s + 10) @(posedge clk);
    #1 start = 1'b1; exp_i = 16'd7;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < s + 100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_result", result, 0);
    for (int n = 0; n < 20; n++) begin
      b = {16'($urandom_range(0, 3)), 16'($urandom), 32'($urandom)};
      e = 16'($urandom) >> $urandom_range(4, 15);
      @(posedge clk); #1 start = 1'b1; base = b; exp_i = e; s = cyc;
      @(posedge clk); #1 start = 1'b0;
      mode = $urandom_range(0, 2);
      k = $urandom_range(1, lat_of(e));
      if (mode != 0) begin
        while (cyc < s + k) @(posedge clk);
        #1 if (mode == 1) abort = 1'b1; else start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
      end
      do @(negedge clk); while (busy && cyc - s < 5000);
      chk("rand_idle", busy, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
